vslc_button_conditioner: RTL and testbench

//  Upstream of the VSLC core on the iCEBreaker: turns raw board buttons into clean ui_in bits.
//  Per channel: 2-FF synchronise, optional inversion, debounce counter.

---
 rtl/vslc_pkg.sv | 20 ++
 rtl/vslc_debounce_ch.sv | 102 ++++++++++
 rtl/vslc_button_conditioner.sv | 49 ++++
 tb/tb_vslc_button_conditioner.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/vslc_pkg.sv
// rtl/vslc_pkg.sv - shared widths and 12 MHz board defaults for the VSLC button conditioner
//
// Purpose: constants shared by vslc_button_conditioner and vslc_debounce_ch.
// Ports: none (package).
package vslc_pkg;

    localparam int VSLC_BTN_N             = 4;
    localparam int VSLC_BTN_CNT_W         = 16;
    localparam int VSLC_BTN_HOLD_W        = 24;

    // 1 ms debounce window at the 12 MHz iCEBreaker clock
    localparam int VSLC_BTN_STABLE_CYCLES = 12000;
    // 0.5 s before the first auto-repeat, then 10 repeats per second
    localparam int VSLC_BTN_REPEAT_DELAY  = 6000000;
    localparam int VSLC_BTN_REPEAT_PERIOD = 1200000;

    // BTN_N on channel 0 is an active-low pad
    localparam logic [VSLC_BTN_N-1:0] VSLC_BTN_INV_MASK = 4'b0001;

endpackage

// File: rtl/vslc_debounce_ch.sv
// rtl/vslc_debounce_ch.sv - one button channel: 2-FF sync, inversion, debounce, edge pulses
//
// Purpose: condition a single asynchronous pad into a clean level plus 1-cycle
//          rise/fall pulses. Optional auto-repeat on rise under VSLC_BTN_AUTOREPEAT_EN.
// Ports:
//   CLK    in   system clock
//   rst    in   synchronous reset, active-high
//   raw    in   asynchronous pad input
//   level  out  debounced level, active-high after inversion
//   rise   out  1-cycle pulse on accepted 0->1 (and auto-repeat)
//   fall   out  1-cycle pulse on accepted 1->0
// Macro: VSLC_BTN_AUTOREPEAT_EN enables the hold counter and repeated rise pulses.
module vslc_debounce_ch
    import vslc_pkg::*;
#(
    parameter int   STABLE_CYCLES = VSLC_BTN_STABLE_CYCLES,
    parameter int   CNT_W         = VSLC_BTN_CNT_W,
    parameter logic INV           = 1'b0,
    parameter int   REPEAT_DELAY  = VSLC_BTN_REPEAT_DELAY,
    parameter int   REPEAT_PERIOD = VSLC_BTN_REPEAT_PERIOD
) (
    input  logic CLK,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(STABLE_CYCLES - 1);

    if (STABLE_CYCLES < 2 || (STABLE_CYCLES - 1) >= (2 ** CNT_W)) begin : g_bad_stable
        $error("vslc_debounce_ch: STABLE_CYCLES must be >= 2 and fit in CNT_W");
    end
    if (REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_repeat
        $error("vslc_debounce_ch: need 1 <= REPEAT_PERIOD <= REPEAT_DELAY");
    end

    // The synchroniser holds pad-domain values, so its reset value is the
    // inactive pad level INV; inversion is applied at the synchroniser output.
    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    logic             sync_val;
    logic             commit;
    logic             rep_hit;

    assign sync_val = s2 ^ INV;
    assign commit   = (sync_val != level) && (cnt == CNT_TERM);

`ifdef VSLC_BTN_AUTOREPEAT_EN
    localparam logic [VSLC_BTN_HOLD_W-1:0] HOLD_FIRE   = VSLC_BTN_HOLD_W'(REPEAT_DELAY);
    // Reloading DELAY-PERIOD makes every later repeat land PERIOD cycles apart
    // while reusing the single compare against HOLD_FIRE.
    localparam logic [VSLC_BTN_HOLD_W-1:0] HOLD_RELOAD = VSLC_BTN_HOLD_W'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [VSLC_BTN_HOLD_W-1:0] hold;
    logic [VSLC_BTN_HOLD_W-1:0] hold_inc;

    assign hold_inc = hold + 1'b1;
    assign rep_hit  = level && (hold_inc == HOLD_FIRE);

    always_ff @(posedge CLK) begin
        if (rst || !level) begin
            hold <= '0;
        end else if (rep_hit) begin
            hold <= HOLD_RELOAD;
        end else begin
            hold <= hold_inc;
        end
    end
`else
    assign rep_hit = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (rst) begin
            s1    <= INV;
            s2    <= INV;
            level <= 1'b0;
            cnt   <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            // A repeat coinciding with an accepted release is dropped so that
            // rise and fall never overlap.
            rise <= (commit && sync_val) || (rep_hit && !commit);
            fall <= commit && !sync_val;
            if (sync_val == level) begin
                cnt <= '0;
            end else if (commit) begin
                level <= sync_val;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vslc_button_conditioner.sv
// rtl/vslc_button_conditioner.sv - N_BTN-channel button conditioner ahead of the VSLC core
//
// Purpose: debounce raw iCEBreaker buttons into clean levels and edge pulses.
//          Integration maps btn_level onto ui_in[0,1,2,4]; the pulses feed
//          edge-sensitive core inputs.
// Ports:
//   CLK        in   system clock, single domain
//   rst        in   synchronous reset, active-high
//   btn_raw    in   [N_BTN] asynchronous pad inputs
//   btn_level  out  [N_BTN] debounced levels, active-high after inversion
//   btn_rise   out  [N_BTN] 1-cycle pulse on 0->1 (and auto-repeat)
//   btn_fall   out  [N_BTN] 1-cycle pulse on 1->0
// Macro: VSLC_BTN_AUTOREPEAT_EN enables auto-repeat rise pulses while held.
module vslc_button_conditioner
    import vslc_pkg::*;
#(
    parameter int               N_BTN         = VSLC_BTN_N,
    parameter int               STABLE_CYCLES = VSLC_BTN_STABLE_CYCLES,
    parameter int               CNT_W         = VSLC_BTN_CNT_W,
    parameter logic [N_BTN-1:0] INV_MASK      = VSLC_BTN_INV_MASK,
    parameter int               REPEAT_DELAY  = VSLC_BTN_REPEAT_DELAY,
    parameter int               REPEAT_PERIOD = VSLC_BTN_REPEAT_PERIOD
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_rise,
    output logic [N_BTN-1:0] btn_fall
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        vslc_debounce_ch #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .CNT_W         (CNT_W),
            .INV           (INV_MASK[i]),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_ch (
            .CLK   (CLK),
            .rst   (rst),
            .raw   (btn_raw[i]),
            .level (btn_level[i]),
            .rise  (btn_rise[i]),
            .fall  (btn_fall[i])
        );
    end

endmodule

// File: tb/tb_vslc_button_conditioner.sv
// tb/tb_vslc_button_conditioner.sv - directed self-checking bench for vslc_button_conditioner
module tb_vslc_button_conditioner;

`ifdef VSLC_BTN_AUTOREPEAT_EN
    localparam int AR = 1;
`else
    localparam int AR = 0;
`endif

    logic       CLK = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn_raw = 4'b0001;
    logic [3:0] btn_level;
    logic [3:0] btn_rise;
    logic [3:0] btn_fall;

    int vectors     = 0;
    int miscompares = 0;
    int rise_cnt[4];
    int fall_cnt[4];

    always #5 CLK = ~CLK;

    vslc_button_conditioner #(
        .N_BTN         (4),
        .STABLE_CYCLES (8),
        .CNT_W         (16),
        .INV_MASK      (4'b0001),
        .REPEAT_DELAY  (40),
        .REPEAT_PERIOD (10)
    ) dut (
        .CLK       (CLK),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .btn_level (btn_level),
        .btn_rise  (btn_rise),
        .btn_fall  (btn_fall)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
        for (int i = 0; i < 4; i++) begin
            rise_cnt[i] += int'(btn_rise[i]);
            fall_cnt[i] += int'(btn_fall[i]);
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic clr();
        for (int i = 0; i < 4; i++) begin
            rise_cnt[i] = 0;
            fall_cnt[i] = 0;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (!rst) begin
            vectors++;
            assert ((btn_rise & btn_fall) === 4'b0000) else begin
                miscompares++;
                $error("FAIL rise_fall_overlap: observed rise=%b fall=%b", btn_rise, btn_fall);
            end
        end
    end

    initial begin
        clr();
        rst     = 1'b1;
        btn_raw = 4'b0001;
        run(3);
        chk("reset_level", int'(btn_level), 0);
        chk("reset_rise",  int'(btn_rise),  0);
        chk("reset_fall",  int'(btn_fall),  0);
        rst = 1'b0;
        run(4);
        chk("idle_inverted_level", int'(btn_level), 0);

        // 1. clean press / release on channel 1
        clr();
        btn_raw[1] = 1'b1;
        run(9);
        chk("t1_level_edge9", int'(btn_level[1]), 0);
        chk("t1_no_early_rise", rise_cnt[1], 0);
        tick();
        chk("t1_level_edge10", int'(btn_level[1]), 1);
        chk("t1_rise_edge10",  int'(btn_rise[1]),  1);
        tick();
        chk("t1_rise_edge11",  int'(btn_rise[1]),  0);
        run(19);
        chk("t1_single_rise",  rise_cnt[1], 1);
        clr();
        btn_raw[1] = 1'b0;
        run(9);
        chk("t1_rel_level_pre", int'(btn_level[1]), 1);
        chk("t1_rel_no_fall",   fall_cnt[1], 0);
        tick();
        chk("t1_rel_fall",      int'(btn_fall[1]),  1);
        chk("t1_rel_level",     int'(btn_level[1]), 0);
        tick();
        chk("t1_rel_fall_off",  int'(btn_fall[1]),  0);

        // 2. bounce on channel 2
        clr();
        for (int k = 0; k < 4; k++) begin
            btn_raw[2] = 1'b1;
            run(5);
            btn_raw[2] = 1'b0;
            run(3);
        end
        chk("t2_bounce_no_rise",  rise_cnt[2], 0);
        chk("t2_bounce_level",    int'(btn_level[2]), 0);
        btn_raw[2] = 1'b1;
        run(9);
        chk("t2_level_edge9",     int'(btn_level[2]), 0);
        tick();
        chk("t2_level_edge10",    int'(btn_level[2]), 1);
        chk("t2_rise_edge10",     int'(btn_rise[2]),  1);
        run(5);
        chk("t2_exactly_one_rise", rise_cnt[2], 1);
        btn_raw[2] = 1'b0;
        run(12);
        chk("t2_released",        int'(btn_level[2]), 0);
        chk("t2_one_fall",        fall_cnt[2], 1);

        // 3. inverted channel 0: pad low means pressed
        clr();
        btn_raw[0] = 1'b0;
        run(9);
        chk("t3_level_edge9",  int'(btn_level[0]), 0);
        tick();
        chk("t3_level_edge10", int'(btn_level[0]), 1);
        chk("t3_rise_edge10",  int'(btn_rise[0]),  1);
        run(2);
        chk("t3_one_rise",     rise_cnt[0], 1);
        btn_raw[0] = 1'b1;
        run(12);
        chk("t3_released",     int'(btn_level[0]), 0);
        chk("t3_one_fall",     fall_cnt[0], 1);

        // 4. reset mid-count on channel 3; rst raised after edge 6, sampled at edge 7
        clr();
        btn_raw[3] = 1'b1;
        run(6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t4_after_reset_level", int'(btn_level), 0);
        run(9);
        chk("t4_level_edge16",  int'(btn_level[3]), 0);
        chk("t4_no_early_rise", rise_cnt[3], 0);
        tick();
        chk("t4_level_edge17",  int'(btn_level[3]), 1);
        chk("t4_rise_edge17",   int'(btn_rise[3]),  1);
        btn_raw[3] = 1'b0;
        run(12);
        chk("t4_released",      int'(btn_level[3]), 0);

        // 5. all channels change on the same edge
        clr();
        btn_raw = 4'b1110;
        run(9);
        chk("t5_level_edge9",  int'(btn_level), 0);
        tick();
        chk("t5_level_all",    int'(btn_level), 15);
        chk("t5_rise_all",     int'(btn_rise),  15);
        chk("t5_fall_none",    int'(btn_fall),  0);
        tick();
        chk("t5_rise_off",     int'(btn_rise),  0);
        btn_raw = 4'b0001;
        run(9);
        chk("t5_rel_level_pre", int'(btn_level), 15);
        tick();
        chk("t5_rel_level",    int'(btn_level), 0);
        chk("t5_rel_fall_all", int'(btn_fall),  15);
        chk("t5_rel_rise_none", int'(btn_rise), 0);

        // 6. long hold on channel 1: auto-repeat when the macro is on
        clr();
        btn_raw[1] = 1'b1;
        run(10);
        chk("t6_accept_rise", int'(btn_rise[1]), 1);
        clr();
        run(39);
        chk("t6_no_rise_before_delay", rise_cnt[1], 0);
        tick();
        chk("t6_rise_at_delay",  int'(btn_rise[1]), AR);
        run(9);
        tick();
        chk("t6_rise_at_period", int'(btn_rise[1]), AR);
        run(50);
        chk("t6_rise_count_100", rise_cnt[1], (AR != 0) ? 7 : 0);
        clr();
        btn_raw[1] = 1'b0;
        run(12);
        chk("t6_release_fall",   fall_cnt[1], 1);
        chk("t6_release_no_rise", rise_cnt[1], 0);
        chk("t6_release_level",  int'(btn_level[1]), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
